ov_frame_reader: RTL
====================

Name: ov_frame_reader

Overview:
- Camera-side frame controller between the OV7670/AL422B frame FIFO and the pixel FIFO that feeds the VGA engine.
- Arms the camera FIFO write for exactly one frame per VSYNC period, then drains it.
- Generates OV_RCLK and assembles byte pairs into RGB565 words.
- Pushes those words into the downstream pixel FIFO with back-pressure, one frame per cycle of operation.

Parameters:
H_ACT, 320, active pixels per line.
V_ACT, 240, active lines per frame.
WRST_CYCLES, 4, CLK cycles OV_WRST is held low at frame arm.
RRST_CYCLES, 4, OV_RCLK periods OV_RRST is held low before reading.

Ports:
CLK  in  1  system clock (80 MHz domain); all logic on rising edge.
RST  in  1  synchronous reset, active-high.
CFG_DONE  in  1  SCCB configuration complete; level.
OV_VSYNC  in  1  camera VSYNC, asynchronous, active-high pulse per frame.
OV_DATA_IN  in  8  AL422B read data.
OV_WRST  out  1  AL422B write-pointer reset, active-low.
OV_WEN  out  1  AL422B write enable, active-high.
OV_RRST  out  1  AL422B read-pointer reset, active-low.
OV_RCLK  out  1  AL422B read clock, registered.
FIFO_FULL  in  1  downstream almost-full; asserted with at least 2 free words.
FIFO_WRREQ  out  1  one-cycle write strobe into the pixel FIFO.
FIFO_DATA  out  16  RGB565 pixel; valid when FIFO_WRREQ=1.
LINE_END  out  1  one-cycle pulse coincident with the last FIFO_WRREQ of each line.
FRAME_DONE  out  1  one-cycle pulse, the cycle after the final pixel write.
BUSY  out  1  high in every state except S_IDLE and S_WAIT_VS.

Behaviour:
Reset values:
- OV_WRST=1, OV_RRST=1, OV_WEN=0, OV_RCLK=0.
- FIFO_WRREQ=0, FIFO_DATA=0, LINE_END=0, FRAME_DONE=0, BUSY=0.
- Counters cleared; state S_IDLE.
- RST asserted mid-operation returns to these values on the next edge. The partially read frame is discarded; no further FIFO_WRREQ is issued.

VSYNC handling:
- OV_VSYNC passes through a 2-flop synchroniser.
- A rising edge is detected on the synchronised signal: vs_rise is one cycle, 3 CLK cycles after the pin edge at worst.

State machine:
- S_IDLE: wait for CFG_DONE=1. CFG_DONE is sampled only here; later deassertion is ignored.
- S_WAIT_VS: on vs_rise, go to S_WRST.
- S_WRST: OV_WRST=0 for WRST_CYCLES cycles; OV_WEN is set to 1 on entry. Then go to S_CAPTURE.
- S_CAPTURE: OV_WEN=1. On the next vs_rise, clear OV_WEN in the same cycle and go to S_RRST.
- S_RRST: OV_RRST=0 while OV_RCLK toggles for RRST_CYCLES full periods (1 CLK high, 1 CLK low). OV_RRST returns high on the low phase of the last period. Then go to S_READ.
- S_READ: byte read = 2 CLK cycles (phase H: RCLK=1; phase L: RCLK=0). OV_DATA_IN is sampled at the CLK edge ending phase L.
  - First byte = FIFO_DATA[15:8], second byte = FIFO_DATA[7:0].
  - FIFO_WRREQ is registered, asserted the cycle after the low byte is sampled: 4-cycle latency from the pixel's first RCLK rise.
  - Throughput is 1 pixel per 4 CLK cycles; the next pixel's phase H overlaps the write cycle.
- Back-pressure:
  - FIFO_FULL is checked only at a pixel boundary, i.e. the cycle that would start the high byte.
  - If FIFO_FULL=1, hold RCLK=0 and stall, with no partial pixels.
  - Resume on the first cycle FIFO_FULL=0. Stall length is unbounded.
- Counters x (0..H_ACT-1) and y (0..V_ACT-1) advance per write. At x=H_ACT-1: LINE_END=1, x wraps to 0, y increments.
  - At the write with x=H_ACT-1 and y=V_ACT-1, go to S_DONE.
- S_DONE: FRAME_DONE=1 for one cycle, counters clear, go to S_WAIT_VS.
- vs_rise in S_WRST, S_RRST, S_READ or S_DONE is ignored. OV_WEN stays 0 outside S_WRST/S_CAPTURE.
- Counter widths: clog2(H_ACT) and clog2(V_ACT) bits, no overflow beyond terminal count.

Test Plan:
1. RST=1 for 3 cycles, then RST=0 with CFG_DONE=0 and VSYNC pulsing -> all outputs at reset values, BUSY=0, OV_WEN stays 0.
2. CFG_DONE=1, VSYNC rise -> OV_WRST low exactly 4 cycles, OV_WEN=1 from the S_WRST entry until the next VSYNC rise. Then OV_WEN=0 and OV_RRST low across 4 RCLK periods.
3. H_ACT=4, V_ACT=2, data bytes 0xF8,0x00,0x07,0xE0,... -> FIFO_DATA 0xF800 then 0x07E0, FIFO_WRREQ every 4 cycles, first strobe 4 cycles after the first post-RRST RCLK rise.
4. Same params, full frame -> exactly 8 FIFO_WRREQ; LINE_END on writes 4 and 8; FRAME_DONE one cycle after write 8; state returns to S_WAIT_VS.
5. FIFO_FULL=1 for 10 cycles mid-line -> RCLK held 0, no FIFO_WRREQ, no byte skipped. Pixel sequence after release is identical to the unstalled reference.
6. RST pulsed during S_READ after 3 pixels -> next edge: RCLK=0, OV_RRST=1, no further writes. A restarted frame begins again at x=0, y=0.

Source files
------------

// File: rtl/ov_frame_reader_if.sv
// rtl/ov_frame_reader_if.sv - pixel FIFO push port between the camera frame reader and the VGA pixel FIFO
interface ov_frame_reader_if;
  logic        wrreq;
  logic [15:0] data;
  logic        full;
  logic        line_end;
  logic        frame_done;

  modport master (output wrreq, data, line_end, frame_done, input full);
  modport slave  (input wrreq, data, line_end, frame_done, output full);
endinterface

// File: rtl/ov_frame_reader.sv
// rtl/ov_frame_reader.sv - arms one AL422B frame per VSYNC, then drains it as RGB565 words into the pixel FIFO
module ov_frame_reader #(
  parameter int H_ACT       = 320,
  parameter int V_ACT       = 240,
  parameter int WRST_CYCLES = 4,
  parameter int RRST_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_done,
  input  logic              i_ov_vsync,
  input  logic [7:0]        i_ov_data,
  output logic              o_ov_wrst,
  output logic              o_ov_wen,
  output logic              o_ov_rrst,
  output logic              o_ov_rclk,
  output logic              o_busy,
  ov_frame_reader_if.master pix
);
  localparam int XW   = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW   = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int CMAX = (WRST_CYCLES > 2 * RRST_CYCLES) ? WRST_CYCLES : 2 * RRST_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] WRST_LAST = CW'(WRST_CYCLES - 1);
  localparam logic [CW-1:0] RRST_LAST = CW'(2 * RRST_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VS, S_WRST, S_CAPTURE, S_RRST, S_READ, S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic          r_vs_meta, r_vs_sync, r_vs_d;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_ph, w_ph;
  logic          r_stall, w_stall;
  logic [7:0]    r_hi, w_hi;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic          r_wrst, w_wrst, r_wen, w_wen, r_rrst, w_rrst, r_rclk, w_rclk;
  logic          r_wrreq, w_wrreq, r_line_end, w_line_end, r_frame_done, w_frame_done;
  logic          r_busy, w_busy;
  logic [15:0]   r_data, w_data;
  logic          w_vs_rise;
  logic          w_start;

  assign w_vs_rise = r_vs_sync & ~r_vs_d;

  // Every output is registered from its next-state value, so pins never glitch on state decode.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_ph         = r_ph;
    w_stall      = r_stall;
    w_hi         = r_hi;
    w_x          = r_x;
    w_y          = r_y;
    w_wrst       = 1'b1;
    w_rrst       = 1'b1;
    w_rclk       = 1'b0;
    w_wrreq      = 1'b0;
    w_data       = r_data;
    w_line_end   = 1'b0;
    w_frame_done = 1'b0;
    w_start      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_cfg_done) w_state = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (w_vs_rise) begin
          w_state = S_WRST;
          w_cnt   = '0;
          w_wrst  = 1'b0;
        end
      end
      S_WRST: begin
        if (r_cnt == WRST_LAST) begin
          w_state = S_CAPTURE;
        end else begin
          w_cnt  = r_cnt + CW'(1);
          w_wrst = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (w_vs_rise) begin
          w_state = S_RRST;
          w_cnt   = '0;
          w_rclk  = 1'b1;
          w_rrst  = 1'b0;
        end
      end
      // Even counts are RCLK high phases; RRST releases on the final low phase.
      S_RRST: begin
        if (r_cnt == RRST_LAST) begin
          w_state = S_READ;
          w_cnt   = '0;
          w_start = 1'b1;
        end else begin
          w_cnt  = r_cnt + CW'(1);
          w_rclk = ~w_cnt[0];
          w_rrst = (w_cnt == RRST_LAST);
        end
      end
      S_READ: begin
        if (r_stall) begin
          w_start = 1'b1;
        end else begin
          unique case (r_ph)
            2'd0: w_ph = 2'd1;
            2'd1: begin
              w_hi   = i_ov_data;
              w_ph   = 2'd2;
              w_rclk = 1'b1;
            end
            2'd2: w_ph = 2'd3;
            default: begin
              w_wrreq = 1'b1;
              w_data  = {r_hi, i_ov_data};
              if (r_x == X_LAST) begin
                w_line_end = 1'b1;
                w_x        = '0;
                if (r_y == Y_LAST) begin
                  w_state = S_DONE;
                end else begin
                  w_y     = r_y + YW'(1);
                  w_start = 1'b1;
                end
              end else begin
                w_x     = r_x + XW'(1);
                w_start = 1'b1;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_x          = '0;
        w_y          = '0;
        w_state      = S_WAIT_VS;
      end
      default: w_state = S_IDLE;
    endcase

    // Pixel boundary: a full downstream FIFO parks RCLK low before any byte of the next pixel.
    if (w_start) begin
      if (pix.full) begin
        w_stall = 1'b1;
        w_rclk  = 1'b0;
      end else begin
        w_stall = 1'b0;
        w_ph    = 2'd0;
        w_rclk  = 1'b1;
      end
    end

    w_wen  = (w_state == S_WRST) || (w_state == S_CAPTURE);
    w_busy = (w_state != S_IDLE) && (w_state != S_WAIT_VS);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_vs_meta    <= 1'b0;
      r_vs_sync    <= 1'b0;
      r_vs_d       <= 1'b0;
      r_cnt        <= '0;
      r_ph         <= 2'd0;
      r_stall      <= 1'b0;
      r_hi         <= 8'h00;
      r_x          <= '0;
      r_y          <= '0;
      r_wrst       <= 1'b1;
      r_wen        <= 1'b0;
      r_rrst       <= 1'b1;
      r_rclk       <= 1'b0;
      r_wrreq      <= 1'b0;
      r_data       <= 16'h0000;
      r_line_end   <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_vs_meta    <= i_ov_vsync;
      r_vs_sync    <= r_vs_meta;
      r_vs_d       <= r_vs_sync;
      r_cnt        <= w_cnt;
      r_ph         <= w_ph;
      r_stall      <= w_stall;
      r_hi         <= w_hi;
      r_x          <= w_x;
      r_y          <= w_y;
      r_wrst       <= w_wrst;
      r_wen        <= w_wen;
      r_rrst       <= w_rrst;
      r_rclk       <= w_rclk;
      r_wrreq      <= w_wrreq;
      r_data       <= w_data;
      r_line_end   <= w_line_end;
      r_frame_done <= w_frame_done;
      r_busy       <= w_busy;
    end
  end

  assign o_ov_wrst      = r_wrst;
  assign o_ov_wen       = r_wen;
  assign o_ov_rrst      = r_rrst;
  assign o_ov_rclk      = r_rclk;
  assign o_busy         = r_busy;
  assign pix.wrreq      = r_wrreq;
  assign pix.data       = r_data;
  assign pix.line_end   = r_line_end;
  assign pix.frame_done = r_frame_done;
endmodule
